// File: rtl/spi_request_arbiter_if.sv
// Bundle between the two SPI requesters, the arbiter and the SPI peripheral.
//   req0_i/req1_i    : request levels from requester 0 / 1
//   cfg0_i/cfg1_i    : control-register words (bit 0 = send)
//   gnt0_o/gnt1_o    : requester currently owns the peripheral
//   done0_o/done1_o  : one-cycle completion pulse per requester
//   err_o            : one-cycle pulse, transaction ended by timeout
//   reg_sel_o, wr_o, data_o : peripheral register write port
//   ctrl_rd_i        : control-register readback, bit 0 = send/busy
// slave  = arbiter side, master = requester/peripheral side.
interface spi_request_arbiter_if #(
  parameter int SW = 16
);
  logic          req0_i, req1_i;
  logic [SW-2:0] cfg0_i, cfg1_i;
  logic          gnt0_o, gnt1_o;
  logic          done0_o, done1_o;
  logic          err_o;
  logic          reg_sel_o;
  logic          wr_o;
  logic [SW-2:0] data_o;
  logic [31:0]   ctrl_rd_i;

  modport slave (
    input  req0_i, req1_i, cfg0_i, cfg1_i, ctrl_rd_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, err_o, reg_sel_o, wr_o, data_o
  );

  modport master (
    output req0_i, req1_i, cfg0_i, cfg1_i, ctrl_rd_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, err_o, reg_sel_o, wr_o, data_o
  );
endinterface

// File: rtl/spi_request_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI peripheral.
// The winner's cfg word is written to the control register with the send
// bit forced, then the arbiter waits for send to rise and fall again (or a
// timeout) before pulsing done (and err on timeout) to the owner.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : spi_request_arbiter_if.slave (requests, grants, peripheral port)
module spi_request_arbiter #(
  parameter int SW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_request_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_SET, WAIT_CLR, RELEASE} state_t;

  state_t        r_state;
  logic          r_owner;   // 0 = requester 0, 1 = requester 1
  logic          r_last;    // owner served last; reset to 1 so requester 0 wins first
  logic [SW-2:0] r_data;
  logic [CW-1:0] r_cnt;
  logic          r_gnt0, r_gnt1, r_done0, r_done1, r_err, r_wr;

  logic w_pick, w_busy, w_to, w_fin;
  logic w_unused_ctrl;

  // Contention goes to whoever was not served last; a lone request wins.
  assign w_pick = (bus.req0_i & bus.req1_i) ? ~r_last : bus.req1_i;
  assign w_busy = bus.ctrl_rd_i[0];
  // Counter is compared before its increment, so the wait lasts TIMEOUT cycles.
  assign w_to   = (r_cnt == CW'(TIMEOUT - 1));
  // Timeout has priority over the busy bit.
  assign w_fin  = w_to | ((r_state == WAIT_CLR) & ~w_busy);
  assign w_unused_ctrl = ^bus.ctrl_rd_i[31:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_data  <= '0;
      r_cnt   <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_wr    <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (bus.req0_i | bus.req1_i) begin
          r_owner <= w_pick;
          r_data  <= w_pick ? {bus.cfg1_i[SW-2:1], 1'b1} : {bus.cfg0_i[SW-2:1], 1'b1};
          r_wr    <= 1'b1;
          r_gnt0  <= ~w_pick;
          r_gnt1  <= w_pick;
          r_state <= WRITE;
        end
        WRITE: begin
          r_cnt   <= '0;
          r_state <= WAIT_SET;
        end
        WAIT_SET, WAIT_CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fin) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= w_to;
            r_state <= RELEASE;
          end else if ((r_state == WAIT_SET) && w_busy) begin
            r_state <= WAIT_CLR;
          end
        end
        RELEASE: begin
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0_o    = r_gnt0;
  assign bus.gnt1_o    = r_gnt1;
  assign bus.done0_o   = r_done0;
  assign bus.done1_o   = r_done1;
  assign bus.err_o     = r_err;
  assign bus.wr_o      = r_wr;
  assign bus.reg_sel_o = 1'b0;
  assign bus.data_o    = r_data;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter: scenario tasks plus a
// randomized run, all checked against a transaction-level reference model.
module tb_spi_request_arbiter;
  localparam int SW = 16;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_request_arbiter_if #(.SW(SW)) bus ();
  spi_request_arbiter #(.SW(SW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pcnt = 0, p_set = 1, p_dur = 1;
  int last_served = 1;
  int gcnt0 = 0, gcnt1 = 0, err_cnt = 0;
  int wr_cyc[$], wr_dat[$], wr_own[$], dn_cyc[$], dn_who[$], dn_err[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: send visible p_set cycles after the write, for p_dur cycles.
  always @(posedge clk or negedge rst)
    if (!rst) pcnt <= 0;
    else if (bus.wr_o) pcnt <= 1;
    else if (pcnt > 0) pcnt <= pcnt + 1;
  assign bus.ctrl_rd_i = {31'b0, (pcnt >= p_set) && (pcnt < p_set + p_dur)};

  // Event log and per-cycle exclusivity rules.
  always @(negedge clk) if (rst) begin
    if (bus.wr_o) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(int'(bus.data_o));
      wr_own.push_back(bus.gnt1_o ? 1 : (bus.gnt0_o ? 0 : -1));
    end
    if (bus.done0_o || bus.done1_o) begin
      dn_cyc.push_back(cyc);
      dn_who.push_back(bus.done1_o ? 1 : 0);
      dn_err.push_back(int'(bus.err_o));
    end
    if (bus.err_o) err_cnt++;
    if (bus.gnt0_o) gcnt0++;
    if (bus.gnt1_o) gcnt1++;
    n_cmp++;
    if ((bus.gnt0_o & bus.gnt1_o) | (bus.done0_o & bus.done1_o) | bus.reg_sel_o |
        (bus.err_o & ~(bus.done0_o | bus.done1_o)) |
        ((bus.done0_o | bus.done1_o) & (bus.gnt0_o | bus.gnt1_o)) |
        (bus.wr_o & ~(bus.gnt0_o ^ bus.gnt1_o))) begin
      n_bad++;
      $display("FAIL invariant @%0d: gnt=%b%b done=%b%b err=%b wr=%b sel=%b; need one gnt/done max, sel=0, err only with done, no gnt at done, one gnt with wr",
               cyc, bus.gnt0_o, bus.gnt1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.wr_o, bus.reg_sel_o);
    end
  end

  // ---------------- reference model ----------------
  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return 1 - last_served;
    return r1 ? 1 : 0;
  endfunction
  // Cycles from WRITE to the done pulse.
  function automatic int lat(int s, int d);
    return ((s + d > TO) ? TO : s + d) + 1;
  endfunction
  function automatic int terr(int s, int d);
    return (s + d >= TO) ? 1 : 0;
  endfunction
  function automatic int qa(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_log();
    wr_cyc.delete(); wr_dat.delete(); wr_own.delete();
    dn_cyc.delete(); dn_who.delete(); dn_err.delete();
    gcnt0 = 0; gcnt1 = 0; err_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    last_served = 1;
    tick();
  endtask

  // Present requests for one IDLE cycle; wc = expected WRITE cycle.
  task automatic launch(input bit r0, input bit r1, input logic [SW-2:0] c0,
                        input logic [SW-2:0] c1, input bit hold, output int wc);
    clr_log();
    bus.cfg0_i = c0; bus.cfg1_i = c1;
    bus.req0_i = r0; bus.req1_i = r1;
    wc = cyc + 1;
    tick();
    if (!hold) begin bus.req0_i = 1'b0; bus.req1_i = 1'b0; end
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dn_cyc.size() > 0) begin to = 1'b0; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    bus.cfg0_i = 15'h7FFF; bus.cfg1_i = 15'h7FFF;
    repeat (3) tick();
    n_cmp++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.wr_o, bus.reg_sel_o} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {bus.gnt0_o, bus.gnt1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.wr_o, bus.reg_sel_o});
    end
    n_cmp++;
    if (bus.data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    rst = 1'b1; last_served = 1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int wc, l; bit to;
    p_set = 2; p_dur = 20; l = lat(2, 20);
    launch(1'b1, 1'b0, 15'h0A50, 15'h0, 1'b0, wc);
    wait_done(400, to);
    repeat (2) tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout: no done within 400 cycles"); end
    n_cmp++; if (wr_cyc.size() != 1) begin n_bad++; $display("FAIL single_wr_count: got %0d want 1", wr_cyc.size()); end
    n_cmp++; if (qa(wr_cyc, 0) != wc) begin n_bad++; $display("FAIL single_wr_cycle: got %0d want %0d", qa(wr_cyc, 0), wc); end
    n_cmp++; if (qa(wr_dat, 0) != 32'h0A51) begin n_bad++; $display("FAIL single_data: got %0h want a51", qa(wr_dat, 0)); end
    n_cmp++; if (qa(wr_own, 0) != 0) begin n_bad++; $display("FAIL single_owner: got %0d want 0", qa(wr_own, 0)); end
    n_cmp++; if (dn_cyc.size() != 1 || qa(dn_who, 0) != 0) begin n_bad++; $display("FAIL single_done: got %0d pulses who=%0d want 1 pulse who=0", dn_cyc.size(), qa(dn_who, 0)); end
    n_cmp++; if (qa(dn_cyc, 0) != wc + l) begin n_bad++; $display("FAIL single_done_cycle: got %0d want %0d", qa(dn_cyc, 0), wc + l); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL single_err: got %0d want 0", err_cnt); end
    n_cmp++; if (gcnt0 != l || gcnt1 != 0) begin n_bad++; $display("FAIL single_gnt: got %0d/%0d want %0d/0", gcnt0, gcnt1, l); end
    n_cmp++; if (bus.data_o !== 15'h0A51 || bus.wr_o !== 1'b0) begin n_bad++; $display("FAIL single_hold: got data=%h wr=%b want 0a51/0", bus.data_o, bus.wr_o); end
    last_served = 0;
  endtask

  task automatic test_contention();
    int want, start; bit to;
    do_reset();
    p_set = 1; p_dur = 1;
    clr_log();
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    start = cyc;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dn_cyc.size() >= 4) begin to = 1'b0; break; end
    end
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    repeat (3) tick();
    n_cmp++; if (to || dn_cyc.size() != 4) begin n_bad++; $display("FAIL cont_count: got %0d dones want 4", dn_cyc.size()); end
    n_cmp++; if (qa(wr_cyc, 0) != start + 1) begin n_bad++; $display("FAIL cont_first_wr: got %0d want %0d", qa(wr_cyc, 0), start + 1); end
    for (int i = 0; i < 4; i++) begin
      want = pick(1'b1, 1'b1);
      n_cmp++; if (qa(dn_who, i) != want || qa(wr_own, i) != want) begin
        n_bad++; $display("FAIL cont_order[%0d]: got done=%0d gnt=%0d want %0d", i, qa(dn_who, i), qa(wr_own, i), want);
      end
      if (i < 3) begin
        n_cmp++; if (qa(wr_cyc, i + 1) != qa(dn_cyc, i) + 2) begin
          n_bad++; $display("FAIL cont_gap[%0d]: got wr@%0d want %0d", i, qa(wr_cyc, i + 1), qa(dn_cyc, i) + 2);
        end
      end
      last_served = want;
    end
  endtask

  task automatic test_timeout();
    int wc; bit to;
    p_set = 100000; p_dur = 1;
    launch(1'b1, 1'b0, 15'h1357, 15'h0, 1'b0, wc);
    wait_done(400, to);
    repeat (2) tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL tmo_wait: no done within 400 cycles"); end
    n_cmp++; if (qa(dn_cyc, 0) != wc + TO + 1) begin n_bad++; $display("FAIL tmo_cycle: got %0d want %0d", qa(dn_cyc, 0), wc + TO + 1); end
    n_cmp++; if (qa(dn_err, 0) != 1 || err_cnt != 1 || qa(dn_who, 0) != 0) begin
      n_bad++; $display("FAIL tmo_err: got err=%0d cnt=%0d who=%0d want 1/1/0", qa(dn_err, 0), err_cnt, qa(dn_who, 0));
    end
    last_served = 0;
    p_set = 1; p_dur = 1;
    launch(1'b0, 1'b1, 15'h0, 15'h0222, 1'b0, wc);
    wait_done(50, to);
    repeat (2) tick();
    n_cmp++; if (to || qa(wr_cyc, 0) != wc || qa(dn_err, 0) != 0) begin
      n_bad++; $display("FAIL tmo_recover: got wr@%0d err=%0d want wr@%0d err=0", qa(wr_cyc, 0), qa(dn_err, 0), wc);
    end
    last_served = 1;
  endtask

  task automatic test_timeout_edge();
    int wc, s; bit to;
    for (int k = 0; k < 2; k++) begin
      s = 4 + k; p_set = s; p_dur = 250;
      launch(1'b1, 1'b0, 15'h0040, 15'h0, 1'b0, wc);
      wait_done(400, to);
      repeat (2) tick();
      n_cmp++; if (to || qa(dn_cyc, 0) != wc + lat(s, 250) || qa(dn_err, 0) != terr(s, 250)) begin
        n_bad++; $display("FAIL tmo_edge[%0d]: got done@%0d err=%0d want done@%0d err=%0d",
          k, qa(dn_cyc, 0), qa(dn_err, 0), wc + lat(s, 250), terr(s, 250));
      end
      last_served = 0;
    end
  endtask

  task automatic test_reset_mid();
    int wc, want; bit to;
    p_set = 2; p_dur = 50;
    launch(1'b1, 1'b0, 15'h0F0F, 15'h0, 1'b0, wc);
    repeat (4) tick();
    n_cmp++; if (bus.gnt0_o !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got gnt0=%b want 1", bus.gnt0_o); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.wr_o, bus.reg_sel_o} !== 7'b0 || bus.data_o !== '0) begin
      n_bad++; $display("FAIL rmid_zero: got ctrl=%b data=%h want 0/0",
        {bus.gnt0_o, bus.gnt1_o, bus.done0_o, bus.done1_o, bus.err_o, bus.wr_o, bus.reg_sel_o}, bus.data_o);
    end
    repeat (3) tick();
    rst = 1'b1; last_served = 1;
    tick();
    n_cmp++; if (dn_cyc.size() != 0 || err_cnt != 0) begin n_bad++; $display("FAIL rmid_nodone: got %0d dones %0d errs want 0", dn_cyc.size(), err_cnt); end
    p_set = 1; p_dur = 3;
    want = pick(1'b1, 1'b1);
    launch(1'b1, 1'b1, 15'h0101, 15'h0202, 1'b0, wc);
    wait_done(50, to);
    repeat (2) tick();
    n_cmp++; if (to || qa(dn_who, 0) != want || qa(dn_cyc, 0) != wc + lat(1, 3)) begin
      n_bad++; $display("FAIL rmid_after: got who=%0d done@%0d want who=%0d done@%0d", qa(dn_who, 0), qa(dn_cyc, 0), want, wc + lat(1, 3));
    end
    last_served = want;
  endtask

  task automatic test_drop_cfg();
    int wc; bit to;
    p_set = 5; p_dur = 4;
    launch(1'b0, 1'b1, 15'h0, 15'h1234, 1'b1, wc);
    tick();
    bus.req1_i = 1'b0; bus.cfg1_i = 15'h6DCB;
    wait_done(50, to);
    repeat (4) tick();
    n_cmp++; if (to || dn_cyc.size() != 1 || qa(dn_who, 0) != 1) begin
      n_bad++; $display("FAIL drop_done: got %0d dones who=%0d want 1 who=1", dn_cyc.size(), qa(dn_who, 0));
    end
    n_cmp++; if (wr_cyc.size() != 1 || qa(wr_dat, 0) != 32'h1235) begin
      n_bad++; $display("FAIL drop_data: got %0d writes data=%0h want 1 of 1235", wr_cyc.size(), qa(wr_dat, 0));
    end
    n_cmp++; if (bus.data_o !== 15'h1235) begin n_bad++; $display("FAIL drop_hold: got %h want 1235", bus.data_o); end
    last_served = 1;
  endtask

  task automatic test_random();
    int wc, s, d, own, wantd, l, pat;
    bit r0, r1, to;
    logic [SW-2:0] c0, c1;
    for (int i = 0; i < 40; i++) begin
      pat = $urandom_range(1, 3);
      r0 = pat[0]; r1 = pat[1];
      c0 = 15'($urandom); c1 = 15'($urandom);
      s = $urandom_range(1, 6); d = $urandom_range(1, 10);
      if ($urandom_range(0, 9) == 0) s = 300;
      p_set = s; p_dur = d;
      own = pick(r0, r1);
      wantd = int'(own == 1 ? c1 : c0) | 1;
      l = lat(s, d);
      launch(r0, r1, c0, c1, 1'b0, wc);
      wait_done(400, to);
      n_cmp++; if (to || qa(wr_own, 0) != own || qa(dn_who, 0) != own) begin
        n_bad++; $display("FAIL rnd_owner[%0d]: got gnt=%0d done=%0d want %0d", i, qa(wr_own, 0), qa(dn_who, 0), own);
      end
      n_cmp++; if (qa(wr_dat, 0) != wantd || qa(wr_cyc, 0) != wc) begin
        n_bad++; $display("FAIL rnd_write[%0d]: got %0h@%0d want %0h@%0d", i, qa(wr_dat, 0), qa(wr_cyc, 0), wantd, wc);
      end
      n_cmp++; if (qa(dn_cyc, 0) != wc + l || qa(dn_err, 0) != terr(s, d)) begin
        n_bad++; $display("FAIL rnd_done[%0d]: got @%0d err=%0d want @%0d err=%0d", i, qa(dn_cyc, 0), qa(dn_err, 0), wc + l, terr(s, d));
      end
      n_cmp++; if ((own == 1 ? gcnt1 : gcnt0) != l) begin
        n_bad++; $display("FAIL rnd_gnt[%0d]: got %0d cycles want %0d", i, own == 1 ? gcnt1 : gcnt0, l);
      end
      last_served = own;
      repeat (2) tick();
    end
  endtask

  initial begin
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    bus.cfg0_i = '0;   bus.cfg1_i = '0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_drop_cfg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_request_arbiter.md
SPI_REQUEST_ARBITER -- requirements
Module: spi_request_arbiter

Interface
REQ-001 The block SHALL have parameter SW, default 16: switch-bus width; configuration/data words are SW-1 bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting on the peripheral per transaction.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_i / req1_i  input  1 each  transaction request levels from requester 0 / 1.
REQ-006 The block SHALL have ports cfg0_i / cfg1_i  input  SW-1 each  control-register word for requester 0 / 1; bit 0 is the send bit.
REQ-007 The block SHALL have ports gnt0_o / gnt1_o  output  1 each  requester owns the SPI peripheral.
REQ-008 The block SHALL have ports done0_o / done1_o  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 The block SHALL have port err_o  output  1  one-cycle pulse: the transaction ended by timeout.
REQ-010 The block SHALL have port reg_sel_o  output  1  peripheral register select; 0 = control register.
REQ-011 The block SHALL have port wr_o  output  1  one-cycle write strobe to the peripheral.
REQ-012 The block SHALL have port data_o  output  SW-1  word written to the peripheral.
REQ-013 The block SHALL have port ctrl_rd_i  input  32  control-register readback; bit 0 = send (busy).

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, WRITE, WAIT_SET, WAIT_CLR, RELEASE.
REQ-015 In IDLE with any request high, the block SHALL select an owner, latch that owner's cfg word, and move to WRITE on the next edge.
REQ-016 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; a single request wins outright.
REQ-017 The round-robin pointer SHALL update in RELEASE to the owner just served.
REQ-018 In WRITE, for exactly one cycle, the block SHALL drive wr_o=1, reg_sel_o=0, and data_o = latched cfg with bit 0 forced to 1.
REQ-019 Outside WRITE, the block SHALL hold wr_o=0 and reg_sel_o=0, and data_o SHALL keep the last latched word with bit 0 forced to 1.
REQ-020 WAIT_SET SHALL wait for ctrl_rd_i[0]=1 and then go to WAIT_CLR; WAIT_CLR SHALL wait for ctrl_rd_i[0]=0 and then go to RELEASE.
REQ-021 The block SHALL keep a timeout counter that clears in WRITE and increments each cycle in WAIT_SET/WAIT_CLR.
REQ-022 When the timeout counter reaches TIMEOUT, the block SHALL go to RELEASE with the error flag set, whatever the state of ctrl_rd_i.
REQ-023 The owner's gnt SHALL be high from WRITE through WAIT_CLR inclusive, and low in IDLE and RELEASE.
REQ-024 In RELEASE, for one cycle, the block SHALL pulse the owner's done; err_o SHALL pulse in the same cycle if the timeout ended the transaction; the FSM SHALL then go to IDLE.
REQ-025 Latency: a request sampled in IDLE at edge k SHALL give WRITE (wr_o=1, gnt=1) in cycle k+1; the minimum transaction is 5 cycles from request to done.
REQ-026 Dropping the request after grant SHALL NOT abort the transaction; it completes and done still pulses.
REQ-027 cfg changes after the latch cycle SHALL be ignored until the next grant.
REQ-028 A request still high in the RELEASE cycle SHALL be treated as a new request and arbitrated in the following IDLE.
REQ-029 At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-030 While rst=0, all outputs (gnt, done, err_o, wr_o, reg_sel_o, data_o) SHALL be 0, the FSM SHALL be in IDLE, and the timeout counter SHALL be 0.
REQ-031 While rst=0, the round-robin pointer SHALL be set so requester 0 wins the first contention.
REQ-032 Asserting rst mid-transaction SHALL abort immediately with no done or err pulse.
REQ-033 Operation SHALL resume in IDLE on the first edge after rst returns to 1.

Verification
REQ-034 Single request: req0=1, cfg0=0x0A50; peripheral model sets send 2 cycles after the write and clears it 20 cycles later -> one wr_o pulse with data_o=0x0A51, gnt0 high throughout, done0 pulses once, err_o=0.
REQ-035 Contention: req0=req1=1 from reset -> requester 0 served first, then requester 1; repeating it -> order alternates 1,0,1.
REQ-036 Timeout: peripheral model never sets send, TIMEOUT=255 -> done0 and err_o pulse together 256 cycles after WRITE; FSM returns to IDLE.
REQ-037 Mid-operation: rst=0 during WAIT_CLR -> all outputs 0 at once, no done pulse; a request after release is served normally.
REQ-038 Request drop and cfg change: deassert req1 and alter cfg1 during WAIT_SET -> transaction completes with the originally latched word; done1 pulses once.
